pkt_framer_tx: RTL and testbench

//  Transmit-side packet framer for the UART command link. Takes one command plus payload per handshake
//  and serializes it LSB-byte-first as F5 | CMD | payload bytes into a byte-wide UART transmitter.

---
 rtl/pkt_link_pkg.sv | 29 ++
 rtl/pkt_framer_tx.sv | 151 +++++++++++++++
 tb/tb_pkt_framer_tx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_link_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_link_pkg : constants, command codes and length helper for the UART link
// Rev 1.0
// ---------------------------------------------------------------------------
package pkt_link_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hF5;
  localparam logic [7:0] CMD_PROG  = 8'h01;
  localparam logic [7:0] CMD_SYM   = 8'h02;
  localparam logic [7:0] CMD_LIMIT = 8'h04;

  localparam int NORM_PAYLD_BYTES = 7;
  localparam int SYM_PAYLD_BYTES  = 5;

  typedef enum logic [7:0] {
    CMDC_NORM = 8'h00,
    CMDC_PROG = 8'h01,
    CMDC_SYM  = 8'h02,
    CMDC_DATA = 8'h03
  } cmd_e;

  // Index of the last payload byte sent in the given mode.
  function automatic logic [2:0] last_payld_idx(input logic sym_mode);
    return sym_mode ? 3'(SYM_PAYLD_BYTES - 1) : 3'(NORM_PAYLD_BYTES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_framer_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_framer_tx : serializes F5 | CMD | payload into a byte-wide UART transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
module pkt_framer_tx #(
  parameter int         MAX_PAYLD_PKT_BITS = 56,
  parameter logic [7:0] HDR_BYTE           = 8'hF5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [7:0]                    i_cmd,
  input  logic [MAX_PAYLD_PKT_BITS-1:0] i_payload,
  output logic                          o_tx_stb,
  output logic [7:0]                    o_tx_data,
  input  logic                          i_tx_busy,
  output logic                          o_done,
  output logic                          o_reject,
  output logic                          o_sym_mode
);
  import pkt_link_pkg::*;

  generate
    if (MAX_PAYLD_PKT_BITS != 56) begin : g_param_check
      $error("pkt_framer_tx: MAX_PAYLD_PKT_BITS must be 56");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_GUARD = 3'd2,
    ST_CMD   = 3'd3,
    ST_PAYLD = 3'd4
  } state_t;

  state_t                          r_state, w_state_nxt;
  state_t                          r_ret_state;
  logic [7:0]                      r_cmd;
  logic [MAX_PAYLD_PKT_BITS-1:0]   r_payload;
  logic                            r_hdr_only;
  logic [2:0]                      r_idx;
  logic [2:0]                      r_last_idx;
  logic                            r_done;
  logic                            r_reject;
  logic                            r_sym;

  logic                            w_illegal;
  logic                            w_accept;
  logic                            w_reject;
  logic                            w_ack;
  logic                            w_frame_end;
  logic                            w_tx_stb;
  logic [7:0]                      w_tx_data;

  // Mode check uses the mode as it stands before this request.
  assign w_illegal = (i_cmd >= CMD_LIMIT) || ((i_cmd == CMD_PROG) && r_sym);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_tx_stb    = 1'b0;
    w_tx_data   = 8'h00;
    w_ack       = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          if (w_illegal) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        w_tx_stb  = 1'b1;
        w_tx_data = HDR_BYTE;
        w_ack     = !i_tx_busy;
        if (w_ack) w_state_nxt = ST_GUARD;
      end
      ST_CMD: begin
        w_tx_stb    = 1'b1;
        w_tx_data   = r_cmd;
        w_ack       = !i_tx_busy;
        w_frame_end = w_ack && r_hdr_only;
        if (w_ack) w_state_nxt = r_hdr_only ? ST_IDLE : ST_GUARD;
      end
      ST_PAYLD: begin
        w_tx_stb    = 1'b1;
        w_tx_data   = r_payload[{r_idx, 3'b000} +: 8];
        w_ack       = !i_tx_busy;
        w_frame_end = w_ack && (r_idx == r_last_idx);
        if (w_ack) w_state_nxt = (r_idx == r_last_idx) ? ST_IDLE : ST_GUARD;
      end
      ST_GUARD: begin
        w_state_nxt = r_ret_state;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ret_state <= ST_CMD;
      r_cmd       <= 8'h00;
      r_payload   <= '0;
      r_hdr_only  <= 1'b0;
      r_idx       <= 3'd0;
      r_last_idx  <= 3'd0;
      r_done      <= 1'b0;
      r_reject    <= 1'b0;
      r_sym       <= 1'b0;
    end else begin
      r_done   <= w_frame_end;
      r_reject <= w_reject;
      if (w_accept) begin
        r_cmd      <= i_cmd;
        r_payload  <= i_payload;
        r_hdr_only <= (i_cmd == CMD_SYM);
        r_last_idx <= last_payld_idx(r_sym);
        r_idx      <= 3'd0;
      end
      if (w_ack) r_ret_state <= (r_state == ST_HDR) ? ST_CMD : ST_PAYLD;
      if (w_ack && (r_state == ST_CMD) && r_hdr_only) r_sym <= 1'b1;
      if (w_ack && (r_state == ST_PAYLD)) begin
        r_idx <= w_frame_end ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  assign o_ready    = (r_state == ST_IDLE);
  assign o_tx_stb   = w_tx_stb;
  assign o_tx_data  = w_tx_data;
  assign o_done     = r_done;
  assign o_reject   = r_reject;
  assign o_sym_mode = r_sym;

endmodule
`default_nettype wire

// File: tb/tb_pkt_framer_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pkt_framer_tx : scoreboard bench for pkt_framer_tx with a 10-cycle txuart model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pkt_framer_tx;

  localparam int TO = 3000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  i_cmd = 8'h00;
  logic [55:0] i_payload = '0;
  logic        o_tx_stb;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic        o_done;
  logic        o_reject;
  logic        o_sym_mode;

  pkt_framer_tx dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_cmd      (i_cmd),
    .i_payload  (i_payload),
    .o_tx_stb   (o_tx_stb),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .o_done     (o_done),
    .o_reject   (o_reject),
    .o_sym_mode (o_sym_mode)
  );

  always #5 i_clk = ~i_clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  int         exp_done = 0, done_cnt = 0;
  int         exp_rej = 0, rej_cnt = 0;
  int         acc_cnt = 0;
  int         guard_viol = 0;
  bit         m_sym = 1'b0;
  bit         force_busy = 1'b0;
  int         busy_cnt = 0;
  bit         acc_pend = 1'b0;
  bit         prev_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign i_tx_busy = force_busy || (busy_cnt != 0);

  // txuart model: busy for 10 cycles starting the cycle after a byte is taken.
  always @(posedge i_clk) begin
    if (acc_pend)          busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge i_clk) begin
    if (prev_acc && o_tx_stb) guard_viol++;
    acc_pend = o_tx_stb && !i_tx_busy && !i_rst;
    prev_acc = acc_pend;
    if (acc_pend) begin
      acc_cnt++;
      if (exp_q.size() == 0) chk("extra_byte", {56'h0, o_tx_data}, 64'hFFFF);
      else                   chk("byte", {56'h0, o_tx_data}, {56'h0, exp_q.pop_front()});
    end
    if (o_done)   done_cnt++;
    if (o_reject) rej_cnt++;
  end

  task automatic send_req(input logic [7:0] cmd, input logic [55:0] pl,
                          input bit hold, input bit b2b);
    int t;
    bit rej;
    @(negedge i_clk);
    i_valid = 1'b1; i_cmd = cmd; i_payload = pl;
    t = 0;
    while (!o_ready && t < TO) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      i_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_on_done", {63'h0, o_done}, 64'd1);
    rej = (cmd >= 8'h04) || (cmd == 8'h01 && m_sym);
    if (rej) begin
      exp_rej++;
    end else begin
      exp_q.push_back(8'hF5);
      exp_q.push_back(cmd);
      if (cmd == 8'h02) begin
        m_sym = 1'b1;
      end else begin
        for (int k = 0; k < (m_sym ? 5 : 7); k++) exp_q.push_back(pl[8*k +: 8]);
      end
      exp_done++;
    end
    @(negedge i_clk);
    chk("reject_pulse", {63'h0, o_reject}, {63'h0, rej});
    chk("ready_after", {63'h0, o_ready}, {63'h0, rej});
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int t = 0;
    while (!(exp_q.size() == 0 && o_ready) && t < TO) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= TO) chk("frame_timeout", 64'd0, 64'd1);
    @(negedge i_clk);
  endtask

  initial begin
    int   t;
    bit   stable;
    logic [7:0] held;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_ready", {63'h0, o_ready}, 64'd1);
    chk("rst_stb", {63'h0, o_tx_stb}, 64'd0);
    chk("rst_data", {56'h0, o_tx_data}, 64'd0);
    chk("rst_done", {63'h0, o_done}, 64'd0);
    chk("rst_reject", {63'h0, o_reject}, 64'd0);
    chk("rst_sym", {63'h0, o_sym_mode}, 64'd0);

    send_req(8'h05, 56'h11223344556677, 1'b0, 1'b0);
    repeat (20) @(negedge i_clk);
    chk("rej05_no_bytes", 64'(acc_cnt), 64'd0);

    send_req(8'h01, 56'hA1A2A3A4A5A6A7, 1'b0, 1'b0);
    wait_frame();
    send_req(8'h00, 56'h07060504030201, 1'b0, 1'b0);
    wait_frame();
    chk("norm_done", 64'(done_cnt), 64'(exp_done));
    chk("norm_sym", {63'h0, o_sym_mode}, 64'd0);

    // Busy stall on the 4th byte of a normal frame.
    t = acc_cnt;
    send_req(8'h03, 56'hDEADBEEFCAFE55, 1'b0, 1'b0);
    while (!(acc_cnt == t + 3 && o_tx_stb && busy_cnt > 0)) @(negedge i_clk);
    force_busy = 1'b1;
    held = o_tx_data;
    stable = 1'b1;
    repeat (50) begin
      @(negedge i_clk);
      if (!o_tx_stb || o_tx_data !== held) stable = 1'b0;
    end
    chk("stall_stable", {63'h0, stable}, 64'd1);
    @(posedge i_clk);
    #1 force_busy = 1'b0;
    wait_frame();

    send_req(8'h02, 56'h0, 1'b0, 1'b0);
    wait_frame();
    chk("sym_after_02", {63'h0, o_sym_mode}, 64'd1);
    send_req(8'h03, 56'hFFEE0504030201, 1'b0, 1'b0);
    wait_frame();
    t = acc_cnt;
    send_req(8'h01, 56'h0, 1'b0, 1'b0);
    repeat (20) @(negedge i_clk);
    chk("rej01_no_bytes", 64'(acc_cnt), 64'(t));

    send_req(8'h00, 56'h0F0E0D0C0B0A09, 1'b1, 1'b0);
    send_req(8'h03, 56'h77665544332211, 1'b0, 1'b1);
    wait_frame();
    chk("b2b_done", 64'(done_cnt), 64'(exp_done));

    // Reset right after the 3rd byte of a frame is accepted.
    t = acc_cnt;
    send_req(8'h00, 56'h01010101010101, 1'b0, 1'b0);
    while (acc_cnt != t + 3) @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    exp_q.delete();
    exp_done--;
    m_sym = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_stb", {63'h0, o_tx_stb}, 64'd0);
    chk("rst_mid_ready", {63'h0, o_ready}, 64'd1);
    chk("rst_mid_sym", {63'h0, o_sym_mode}, 64'd0);
    i_rst = 1'b0;
    t = acc_cnt;
    repeat (5) @(negedge i_clk);
    chk("rst_mid_quiet", 64'(acc_cnt), 64'(t));
    send_req(8'h00, 56'h37363534333231, 1'b0, 1'b0);
    wait_frame();
    chk("fresh_frame_len", 64'(acc_cnt - t), 64'd9);

    chk("done_total", 64'(done_cnt), 64'(exp_done));
    chk("reject_total", 64'(rej_cnt), 64'(exp_rej));
    chk("guard_rule", 64'(guard_viol), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
`default_nettype wire
